// File: rtl/tpu_pkg.sv
// Shared TPU definitions: datapath/buffer sizing, the activation-loader
// state encoding and tile geometry.
package tpu_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned UB_ADDR_W  = 13;
    localparam int unsigned UB_DEPTH   = 64;
    localparam int unsigned TILE_WORDS = 4;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        LATCH,
        FEED0,
        FEED1,
        FEED2
    } setup_state_t;

endpackage

// File: rtl/input_setup_if.sv
// Unified buffer read bus between the activation loader and the buffer.
//   ub_load_input : read strobe (loader -> buffer)
//   ub_addr       : tile base address (loader -> buffer)
//   ub_in_00..11  : the four tile words, registered by the buffer at the
//                   strobe edge and held until the next strobe
interface input_setup_if #(
    parameter int unsigned DATA_W    = tpu_pkg::DATA_W,
    parameter int unsigned UB_ADDR_W = tpu_pkg::UB_ADDR_W
);
    logic                 ub_load_input;
    logic [UB_ADDR_W-1:0] ub_addr;
    logic [DATA_W-1:0]    ub_in_00;
    logic [DATA_W-1:0]    ub_in_01;
    logic [DATA_W-1:0]    ub_in_10;
    logic [DATA_W-1:0]    ub_in_11;

    modport master (
        output ub_load_input, ub_addr,
        input  ub_in_00, ub_in_01, ub_in_10, ub_in_11
    );

    modport slave (
        input  ub_load_input, ub_addr,
        output ub_in_00, ub_in_01, ub_in_10, ub_in_11
    );
endinterface

// File: rtl/input_setup_skew_delay.sv
// skew_delay: one-stage register for a data word plus its valid flag.
// Chaining N instances skews row N of a systolic array by N cycles.
//   clk, reset : clock, synchronous active-high reset
//   d, d_valid : undelayed stream
//   q, q_valid : stream delayed by one cycle
module skew_delay #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    input  logic         d_valid,
    output logic [W-1:0] q,
    output logic         q_valid
);
    always_ff @(posedge clk) begin
        if (reset) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            q       <= d;
            q_valid <= d_valid;
        end
    end
endmodule

// File: rtl/input_setup.sv
// input_setup: reads one 2x2 activation tile from the unified buffer and
// feeds it diagonally skewed into the two rows of the systolic array.
//   clk, reset          : clock, synchronous active-high reset
//   start, base_addr    : tile load request and its base address (IDLE only)
//   ub                  : unified buffer read bus (master side)
//   a_in1/valid1        : row-1 activation stream
//   a_in2/valid2        : row-2 activation stream, one cycle behind row 1
//   busy                : high REQ..FEED2
//   done                : pulse on the last feed cycle
//   addr_err            : pulse when a start is rejected for a bad address
module input_setup #(
    parameter int unsigned DATA_W    = tpu_pkg::DATA_W,
    parameter int unsigned UB_ADDR_W = tpu_pkg::UB_ADDR_W,
    parameter int unsigned UB_DEPTH  = tpu_pkg::UB_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [UB_ADDR_W-1:0] base_addr,
    input_setup_if.master        ub,
    output logic [DATA_W-1:0]    a_in1,
    output logic [DATA_W-1:0]    a_in2,
    output logic                 valid1,
    output logic                 valid2,
    output logic                 busy,
    output logic                 done,
    output logic                 addr_err
);
    import tpu_pkg::*;

    localparam logic [UB_ADDR_W-1:0] MAX_BASE = UB_ADDR_W'(UB_DEPTH - TILE_WORDS);

    setup_state_t      state;
    logic [DATA_W-1:0] r01, r10, r11;
    logic [DATA_W-1:0] row2_d;
    logic              row2_dv;

    // Undelayed row-2 sequence {r10, r11}; skew_delay shifts it one cycle
    // behind row 1.
    always_comb begin
        row2_d  = '0;
        row2_dv = 1'b0;
        case (state)
            FEED0: begin
                row2_d  = r10;
                row2_dv = 1'b1;
            end
            FEED1: begin
                row2_d  = r11;
                row2_dv = 1'b1;
            end
            default: ;
        endcase
    end

    skew_delay #(.W(DATA_W)) u_row2_skew (
        .clk     (clk),
        .reset   (reset),
        .d       (row2_d),
        .d_valid (row2_dv),
        .q       (a_in2),
        .q_valid (valid2)
    );

    // Word 00 is only ever presented in FEED0, so the a_in1 register loaded
    // at the end of LATCH is its capture register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            ub.ub_load_input <= 1'b0;
            ub.ub_addr       <= '0;
            r01              <= '0;
            r10              <= '0;
            r11              <= '0;
            a_in1            <= '0;
            valid1           <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            addr_err         <= 1'b0;
        end else begin
            ub.ub_load_input <= 1'b0;
            done             <= 1'b0;
            addr_err         <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (base_addr <= MAX_BASE) begin
                            state            <= REQ;
                            ub.ub_load_input <= 1'b1;
                            ub.ub_addr       <= base_addr;
                            busy             <= 1'b1;
                        end else begin
                            addr_err <= 1'b1;
                        end
                    end
                end
                REQ: state <= LATCH;
                LATCH: begin
                    a_in1  <= ub.ub_in_00;
                    r01    <= ub.ub_in_01;
                    r10    <= ub.ub_in_10;
                    r11    <= ub.ub_in_11;
                    valid1 <= 1'b1;
                    state  <= FEED0;
                end
                FEED0: begin
                    a_in1 <= r01;
                    state <= FEED1;
                end
                FEED1: begin
                    a_in1  <= '0;
                    valid1 <= 1'b0;
                    done   <= 1'b1;
                    state  <= FEED2;
                end
                FEED2: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_input_setup.sv
// Directed bench for input_setup with a behavioural unified buffer.
module tb_input_setup;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [12:0] base_addr;
    logic [31:0] a_in1, a_in2;
    logic        valid1, valid2, busy, done, addr_err;

    logic [31:0] mem [64];
    logic        scramble;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    input_setup_if ub_if ();

    input_setup dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .ub        (ub_if.master),
        .a_in1     (a_in1),
        .a_in2     (a_in2),
        .valid1    (valid1),
        .valid2    (valid2),
        .busy      (busy),
        .done      (done),
        .addr_err  (addr_err)
    );

    // Buffer model: registers the tile at the strobe edge, holds it otherwise.
    // scramble perturbs the held words to prove the loader captured them.
    always @(posedge clk) begin
        if (reset) begin
            ub_if.ub_in_00 <= '0;
            ub_if.ub_in_01 <= '0;
            ub_if.ub_in_10 <= '0;
            ub_if.ub_in_11 <= '0;
        end else if (ub_if.ub_load_input) begin
            ub_if.ub_in_00 <= mem[ub_if.ub_addr[5:0]];
            ub_if.ub_in_01 <= mem[ub_if.ub_addr[5:0] + 6'd1];
            ub_if.ub_in_10 <= mem[ub_if.ub_addr[5:0] + 6'd2];
            ub_if.ub_in_11 <= mem[ub_if.ub_addr[5:0] + 6'd3];
        end else if (scramble) begin
            ub_if.ub_in_00 <= ub_if.ub_in_00 ^ 32'hDEAD_BEEF;
            ub_if.ub_in_01 <= ub_if.ub_in_01 ^ 32'h1234_5678;
            ub_if.ub_in_10 <= ub_if.ub_in_10 ^ 32'h0F0F_0F0F;
            ub_if.ub_in_11 <= ub_if.ub_in_11 ^ 32'hA5A5_A5A5;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic chk_feed(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                            input logic ev1, input logic ev2, input logic ed);
        chk({tag, ".a_in1"}, a_in1, e1);
        chk({tag, ".a_in2"}, a_in2, e2);
        chk({tag, ".valid1"}, {31'd0, valid1}, {31'd0, ev1});
        chk({tag, ".valid2"}, {31'd0, valid2}, {31'd0, ev2});
        chk({tag, ".done"}, {31'd0, done}, {31'd0, ed});
    endtask

    // Full tile from a start in cycle 0 through the IDLE cycle 6.
    task automatic run_tile(input string tag, input logic [12:0] base,
                            input logic [31:0] e00, input logic [31:0] e01,
                            input logic [31:0] e10, input logic [31:0] e11,
                            input bit scr);
        start = 1'b1;
        base_addr = base;
        step();  // cycle 1: REQ
        chk({tag, ".c1.load"}, {31'd0, ub_if.ub_load_input}, 32'd1);
        chk({tag, ".c1.addr"}, {19'd0, ub_if.ub_addr}, {19'd0, base});
        chk({tag, ".c1.busy"}, {31'd0, busy}, 32'd1);
        start = 1'b0;
        step();  // cycle 2: LATCH
        chk({tag, ".c2.load"}, {31'd0, ub_if.ub_load_input}, 32'd0);
        chk({tag, ".c2.addr"}, {19'd0, ub_if.ub_addr}, {19'd0, base});
        if (scr) scramble = 1'b1;
        step();
        chk_feed({tag, ".c3"}, e00, 32'd0, 1'b1, 1'b0, 1'b0);
        step();
        chk_feed({tag, ".c4"}, e01, e10, 1'b1, 1'b1, 1'b0);
        step();
        chk_feed({tag, ".c5"}, 32'd0, e11, 1'b0, 1'b1, 1'b1);
        chk({tag, ".c5.busy"}, {31'd0, busy}, 32'd1);
        scramble = 1'b0;
        step();  // cycle 6: IDLE
        chk_feed({tag, ".c6"}, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk({tag, ".c6.busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[30] = 32'd11; mem[31] = 32'd12; mem[32] = 32'd21; mem[33] = 32'd22;
        mem[60] = 32'd1;  mem[61] = 32'd2;  mem[62] = 32'd3;  mem[63] = 32'd4;
        scramble  = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        reset     = 1'b1;
        step();
        step();
        chk_feed("rst", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.err", {31'd0, addr_err}, 32'd0);
        chk("rst.load", {31'd0, ub_if.ub_load_input}, 32'd0);
        chk("rst.addr", {19'd0, ub_if.ub_addr}, 32'd0);
        reset = 1'b0;
        step();

        run_tile("t30", 13'd30, 32'd11, 32'd12, 32'd21, 32'd22, 1'b0);

        // Out-of-range base is rejected.
        start = 1'b1;
        base_addr = 13'd61;
        step();
        chk("bad.c1.err", {31'd0, addr_err}, 32'd1);
        chk("bad.c1.load", {31'd0, ub_if.ub_load_input}, 32'd0);
        chk("bad.c1.busy", {31'd0, busy}, 32'd0);
        start = 1'b0;
        step();
        chk("bad.c2.err", {31'd0, addr_err}, 32'd0);
        chk("bad.c2.addr", {19'd0, ub_if.ub_addr}, 32'd30);
        chk_feed("bad.c2", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        step();

        run_tile("t60", 13'd60, 32'd1, 32'd2, 32'd3, 32'd4, 1'b0);

        // Continuous start: tiles accepted at E0 and E6 only.
        start = 1'b1;
        base_addr = 13'd30;
        for (int c = 1; c <= 7; c++) begin
            step();
            chk($sformatf("hold.c%0d.load", c), {31'd0, ub_if.ub_load_input},
                (c == 1 || c == 7) ? 32'd1 : 32'd0);
            chk($sformatf("hold.c%0d.busy", c), {31'd0, busy},
                (c == 6) ? 32'd0 : 32'd1);
        end
        start = 1'b0;
        step();  // cycle 8 LATCH
        step();  // cycle 9 FEED0
        chk_feed("hold.c9", 32'd11, 32'd0, 1'b1, 1'b0, 1'b0);
        step();
        step();
        step();  // cycle 12 IDLE
        chk("hold.c12.busy", {31'd0, busy}, 32'd0);

        // Reset during FEED1.
        start = 1'b1;
        base_addr = 13'd30;
        step();
        start = 1'b0;
        step();
        step();
        step();  // cycle 4
        chk_feed("mid.c4", 32'd12, 32'd21, 1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        step();  // cycle 5
        chk_feed("mid.c5", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("mid.c5.busy", {31'd0, busy}, 32'd0);
        chk("mid.c5.load", {31'd0, ub_if.ub_load_input}, 32'd0);
        chk("mid.c5.addr", {19'd0, ub_if.ub_addr}, 32'd0);
        reset = 1'b0;
        step();
        chk("mid.c6.done", {31'd0, done}, 32'd0);
        step();
        chk("mid.c7.done", {31'd0, done}, 32'd0);
        run_tile("post", 13'd30, 32'd11, 32'd12, 32'd21, 32'd22, 1'b0);

        // Buffer data changes after LATCH must not reach the feed outputs.
        run_tile("scr", 13'd60, 32'd1, 32'd2, 32'd3, 32'd4, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
